// File: rtl/settings_reg_responder.sv
// Settings-bus responder: writes a register bank and returns one readback word per
// accepted transaction through a 2-entry ready/valid output queue.
module settings_reg_responder #(
    parameter int unsigned          SR_AWIDTH = 8,
    parameter int unsigned          SR_DWIDTH = 32,
    parameter int unsigned          RB_AWIDTH = 8,
    parameter int unsigned          RB_DWIDTH = 64,
    parameter int unsigned          NUM_REGS  = 16,
    parameter int unsigned          BASE      = 0,
    parameter logic [SR_DWIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          set_stb,
    input  logic [SR_AWIDTH-1:0]          set_addr,
    input  logic [SR_DWIDTH-1:0]          set_data,
    input  logic [RB_AWIDTH-1:0]          rb_addr,
    output logic                          set_ready,
    output logic                          rb_stb,
    output logic [RB_DWIDTH-1:0]          rb_data,
    input  logic                          rb_ready,
    input  logic [RB_DWIDTH-1:0]          status_in,
    output logic [NUM_REGS*SR_DWIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]           reg_changed
);

    localparam int unsigned CNT_W = 32;

    logic [SR_DWIDTH-1:0] regs_q [NUM_REGS];
    logic [SR_DWIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  changed_q, changed_d;
    logic [RB_DWIDTH-1:0] mem_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic [CNT_W-1:0]     txn_cnt_q, txn_cnt_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic                 accept, drop, pop, wr_hit;
    logic [31:0]          set_off, rb_sel;
    logic [RB_DWIDTH-1:0] rb_word;

    // Ready depends only on registered occupancy, held low during reset
    assign set_ready = ~reset && (count_q < 2'd2);
    assign accept    = set_stb & set_ready;
    assign drop      = set_stb & ~set_ready;
    assign pop       = rb_stb & rb_ready;
    assign rb_stb    = (count_q != 2'd0);
    assign rb_data   = mem_q[rd_ptr_q];
    assign reg_changed = changed_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*SR_DWIDTH +: SR_DWIDTH] = regs_q[g];
    end

    // Register write decode; produces post-write state used by readback
    always_comb begin
        regs_d    = regs_q;
        changed_d = '0;
        set_off   = 32'(set_addr) - 32'(BASE);
        wr_hit    = accept && (32'(set_addr) >= 32'(BASE)) && (set_off < 32'(NUM_REGS));
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit && set_off == 32'(i)) begin
                regs_d[i]    = set_data;
                changed_d[i] = 1'b1;
            end
        end
    end

    // Counters and readback word selection
    always_comb begin
        txn_cnt_d  = accept ? txn_cnt_q + 32'd1 : txn_cnt_q;
        drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + 32'd1 : drop_cnt_q;
        rb_sel     = 32'(rb_addr);
        rb_word    = '0;
        if (rb_sel == 32'(NUM_REGS)) begin
            rb_word = RB_DWIDTH'(txn_cnt_d);
        end else if (rb_sel == 32'(NUM_REGS + 1)) begin
            rb_word = status_in;
        end else if (rb_sel == 32'(NUM_REGS + 2)) begin
            rb_word = RB_DWIDTH'(drop_cnt_q);
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rb_sel == 32'(i)) rb_word = RB_DWIDTH'(regs_d[i]);
            end
        end
    end

    // Queue occupancy: push and pop together leave the count unchanged
    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 2'd1;
        else if (!accept && pop) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q     <= '{default: RESET_VAL};
            changed_q  <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            txn_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            changed_q  <= changed_d;
            count_q    <= count_d;
            txn_cnt_q  <= txn_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= rb_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_settings_reg_responder.sv
// Directed testbench for settings_reg_responder with default parameters.
module tb_settings_reg_responder;

    localparam int unsigned NR = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          set_stb;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic [7:0]    rb_addr;
    logic          set_ready;
    logic          rb_stb;
    logic [63:0]   rb_data;
    logic          rb_ready;
    logic [63:0]   status_in;
    logic [NR*32-1:0] regs_out;
    logic [NR-1:0] reg_changed;

    int tests_run    = 0;
    int tests_failed = 0;

    settings_reg_responder dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .rb_addr(rb_addr), .set_ready(set_ready),
        .rb_stb(rb_stb), .rb_data(rb_data), .rb_ready(rb_ready),
        .status_in(status_in), .regs_out(regs_out), .reg_changed(reg_changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_stb = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [31:0] d, input logic [7:0] r);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        rb_addr  = r;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_stb = 1'b0;
        tick();
        tests_run++;
        if (set_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready_low: got %b expected 0", set_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (set_ready !== 1'b1 || rb_stb !== 1'b0 || rb_data !== 64'd0 || reg_changed !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b stb=%b data=%h chg=%h expected 1 0 0 0",
                     set_ready, rb_stb, rb_data, reg_changed);
        end
        tests_run++;
        if (regs_out !== '0) begin
            tests_failed++; $display("FAIL reset_regs: got %h expected 0", regs_out);
        end
    endtask

    task automatic test_write();
        rb_ready = 1'b1;
        drive(8'd3, 32'hDEADBEEF, 8'd3);
        tick();
        set_stb = 1'b0;
        tests_run++;
        if (rb_stb !== 1'b1 || rb_data !== 64'h00000000DEADBEEF) begin
            tests_failed++;
            $display("FAIL write_readback: got stb=%b data=%h expected 1 00000000deadbeef", rb_stb, rb_data);
        end
        tests_run++;
        if (reg_changed !== 16'h0008) begin
            tests_failed++; $display("FAIL write_changed: got %h expected 0008", reg_changed);
        end
        tests_run++;
        if (regs_out[3*32 +: 32] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL write_reg3: got %h expected deadbeef", regs_out[3*32 +: 32]);
        end
        tick();
        tests_run++;
        if (reg_changed !== 16'h0000 || rb_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_pulse_end: got chg=%h stb=%b expected 0000 0", reg_changed, rb_stb);
        end
    endtask

    task automatic test_back_to_back();
        rb_ready = 1'b0;
        drive(8'd1, 32'h11, 8'd1);
        tick();
        tests_run++;
        if (set_ready !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_ready_after1: got %b expected 1", set_ready);
        end
        drive(8'd2, 32'h22, 8'd2);
        tick();
        tests_run++;
        if (set_ready !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_ready_after2: got %b expected 0", set_ready);
        end
        drive(8'd4, 32'h44, 8'd4);
        tick();
        set_stb = 1'b0;
        tests_run++;
        if (regs_out[4*32 +: 32] !== 32'h0 || reg_changed !== 16'h0000) begin
            tests_failed++;
            $display("FAIL b2b_drop_nowrite: got reg4=%h chg=%h expected 0 0000",
                     regs_out[4*32 +: 32], reg_changed);
        end
        tests_run++;
        if (rb_stb !== 1'b1 || rb_data !== 64'h11) begin
            tests_failed++; $display("FAIL b2b_head: got stb=%b data=%h expected 1 11", rb_stb, rb_data);
        end
        tick();
        tests_run++;
        if (rb_stb !== 1'b1 || rb_data !== 64'h11) begin
            tests_failed++; $display("FAIL b2b_hold: got stb=%b data=%h expected 1 11", rb_stb, rb_data);
        end
        rb_ready = 1'b1;
        tick();
        tests_run++;
        if (rb_stb !== 1'b1 || rb_data !== 64'h22) begin
            tests_failed++; $display("FAIL b2b_second: got stb=%b data=%h expected 1 22", rb_stb, rb_data);
        end
        tick();
        tests_run++;
        if (rb_stb !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_empty: got %b expected 0", rb_stb);
        end
        drive(8'hFF, 32'h0, 8'(NR + 2));
        tick();
        set_stb = 1'b0;
        tests_run++;
        if (rb_stb !== 1'b1 || rb_data !== 64'd1) begin
            tests_failed++; $display("FAIL b2b_dropcount: got stb=%b data=%h expected 1 1", rb_stb, rb_data);
        end
        tick();
    endtask

    task automatic test_txn_count();
        do_reset();
        rb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(8'hF0, 32'(i), 8'(NR));
            tick();
            tests_run++;
            if (rb_stb !== 1'b1 || rb_data !== 64'(i + 1)) begin
                tests_failed++;
                $display("FAIL txn_count_%0d: got stb=%b data=%h expected 1 %h", i, rb_stb, rb_data, 64'(i + 1));
            end
        end
        set_stb = 1'b0;
        tick();
    endtask

    task automatic test_out_of_window();
        rb_ready = 1'b1;
        drive(8'(NR), 32'hCAFEF00D, 8'd20);
        tick();
        set_stb = 1'b0;
        tests_run++;
        if (reg_changed !== 16'h0000 || regs_out !== '0) begin
            tests_failed++;
            $display("FAIL oow_nowrite: got chg=%h regs_nonzero=%b expected 0000 0", reg_changed, |regs_out);
        end
        tests_run++;
        if (rb_stb !== 1'b1 || rb_data !== 64'd0) begin
            tests_failed++; $display("FAIL oow_readback: got stb=%b data=%h expected 1 0", rb_stb, rb_data);
        end
        tick();
    endtask

    task automatic test_status();
        rb_ready = 1'b0;
        status_in = 64'h123456789ABCDEF0;
        drive(8'hF0, 32'h0, 8'(NR + 1));
        tick();
        set_stb = 1'b0;
        status_in = 64'hFFFF0000FFFF0000;
        tick();
        tests_run++;
        if (rb_stb !== 1'b1 || rb_data !== 64'h123456789ABCDEF0) begin
            tests_failed++;
            $display("FAIL status_sample: got stb=%b data=%h expected 1 123456789abcdef0", rb_stb, rb_data);
        end
        rb_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_op();
        rb_ready = 1'b0;
        drive(8'd5, 32'h55, 8'd5);
        tick();
        drive(8'd6, 32'h66, 8'd6);
        tick();
        set_stb = 1'b0;
        tests_run++;
        if (set_ready !== 1'b0 || reg_changed !== 16'h0040) begin
            tests_failed++;
            $display("FAIL midrst_full: got ready=%b chg=%h expected 0 0040", set_ready, reg_changed);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (rb_stb !== 1'b0 || set_ready !== 1'b1 || reg_changed !== '0 || regs_out !== '0) begin
            tests_failed++;
            $display("FAIL midrst_cleared: got stb=%b ready=%b chg=%h regs_nonzero=%b expected 0 1 0000 0",
                     rb_stb, set_ready, reg_changed, |regs_out);
        end
        rb_ready = 1'b1;
        drive(8'hF0, 32'h0, 8'(NR));
        tick();
        tests_run++;
        if (rb_data !== 64'd1) begin
            tests_failed++; $display("FAIL midrst_txncnt: got %h expected 1", rb_data);
        end
        drive(8'hF0, 32'h0, 8'(NR + 2));
        tick();
        set_stb = 1'b0;
        tests_run++;
        if (rb_data !== 64'd0) begin
            tests_failed++; $display("FAIL midrst_dropcnt: got %h expected 0", rb_data);
        end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        set_stb   = 1'b0;
        set_addr  = '0;
        set_data  = '0;
        rb_addr   = '0;
        rb_ready  = 1'b0;
        status_in = '0;
        test_reset();
        test_write();
        test_back_to_back();
        test_txn_count();
        test_out_of_window();
        test_status();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
